// File: rtl/reg_access_master.sv
// reg_access_master: parses CMD/ADDR[/DATA] byte frames from the UART and drives the register file strobes.
// Optional trailing XOR checksum byte is enabled by defining REG_ACCESS_CHECKSUM_EN.
module reg_access_master #(
   parameter int         DEPTH       = 20,
   parameter logic [7:0] BASE_ADDR   = 8'h40,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       reg_write,
   output logic       reg_read,
   output logic [7:0] reg_index,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   localparam logic [7:0]  CMD_W   = 8'h57;
   localparam logic [7:0]  CMD_R   = 8'h52;
   localparam logic [7:0]  ACK     = 8'h06;
   localparam logic [7:0]  NAK     = 8'h15;
   localparam logic [8:0]  ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [8:0]  ADDR_HI = ADDR_LO + 9'(DEPTH);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
`ifdef REG_ACCESS_CHECKSUM_EN
      GET_SUM,
`endif
      EXEC,
      RESP
   } state_t;

   state_t      state_r;
   state_t      next_get_s;
   logic [15:0] cnt_r;
   logic        is_wr_r;
   logic [7:0]  addr_r;
   logic [7:0]  data_r;
   logic        nak_r;
   logic [7:0]  tx_data_r;
   logic        tx_valid_r;
   logic        reg_write_r;
   logic        reg_read_r;
   logic [7:0]  reg_index_r;
   logic [7:0]  reg_wdata_r;
   logic        busy_r;
   logic [7:0]  frame_addr_s;
   logic [7:0]  frame_data_s;
   logic        last_byte_s;
   logic        sum_ok_s;
   logic        hit_s;

   function automatic logic addr_in_range(input logic [7:0] a);
      return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI);
   endfunction

`ifdef REG_ACCESS_CHECKSUM_EN
   function automatic logic [7:0] frame_sum(input logic is_wr, input logic [7:0] a, input logic [7:0] d);
      return (is_wr ? CMD_W : CMD_R) ^ a ^ (is_wr ? d : 8'h00);
   endfunction
`endif

   // Frame byte routing: which byte completes the frame, and whether it addresses a valid register.
   always_comb begin
      frame_addr_s = addr_r;
      frame_data_s = data_r;
      last_byte_s  = 1'b0;
      next_get_s   = IDLE;
      sum_ok_s     = 1'b1;
      case (state_r)
         GET_ADDR: begin
            frame_addr_s = rx_data;
`ifdef REG_ACCESS_CHECKSUM_EN
            next_get_s   = is_wr_r ? GET_DATA : GET_SUM;
`else
            last_byte_s  = !is_wr_r;
            next_get_s   = GET_DATA;
`endif
         end
         GET_DATA: begin
            frame_data_s = rx_data;
`ifdef REG_ACCESS_CHECKSUM_EN
            next_get_s   = GET_SUM;
`else
            last_byte_s  = 1'b1;
`endif
         end
`ifdef REG_ACCESS_CHECKSUM_EN
         GET_SUM: begin
            last_byte_s = 1'b1;
            sum_ok_s    = (rx_data == frame_sum(is_wr_r, addr_r, data_r));
         end
`endif
         default: begin
            last_byte_s = 1'b0;
         end
      endcase
      // A bad checksum suppresses the strobe regardless of the address.
      hit_s = sum_ok_s && addr_in_range(frame_addr_s);
   end

   // Frame sequencer: collects bytes, issues the single-cycle strobe, holds the response until accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= 16'd0;
         is_wr_r     <= 1'b0;
         addr_r      <= 8'h00;
         data_r      <= 8'h00;
         nak_r       <= 1'b0;
         tx_data_r   <= 8'h00;
         tx_valid_r  <= 1'b0;
         reg_write_r <= 1'b0;
         reg_read_r  <= 1'b0;
         reg_index_r <= 8'h00;
         reg_wdata_r <= 8'h00;
         busy_r      <= 1'b0;
      end else begin
         reg_write_r <= 1'b0;
         reg_read_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= 16'd0;
               if (rx_valid && (rx_data == CMD_W || rx_data == CMD_R)) begin
                  is_wr_r <= (rx_data == CMD_W);
                  state_r <= GET_ADDR;
                  busy_r  <= 1'b1;
               end
            end
`ifdef REG_ACCESS_CHECKSUM_EN
            GET_ADDR, GET_DATA, GET_SUM: begin
`else
            GET_ADDR, GET_DATA: begin
`endif
               if (rx_valid) begin
                  cnt_r  <= 16'd0;
                  addr_r <= frame_addr_s;
                  data_r <= frame_data_s;
                  if (last_byte_s) begin
                     state_r <= EXEC;
                     nak_r   <= !hit_s;
                     if (hit_s) begin
                        reg_index_r <= frame_addr_s - BASE_ADDR;
                        reg_write_r <= is_wr_r;
                        reg_read_r  <= !is_wr_r;
                        if (is_wr_r) begin
                           reg_wdata_r <= frame_data_s;
                        end
                     end
                  end else begin
                     state_r <= next_get_s;
                  end
               end else if (cnt_r == TO_LAST) begin
                  state_r <= IDLE;
                  cnt_r   <= 16'd0;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            EXEC: begin
               tx_data_r  <= nak_r ? NAK : (is_wr_r ? ACK : reg_rdata);
               tx_valid_r <= 1'b1;
               state_r    <= RESP;
            end
            RESP: begin
               if (tx_ready) begin
                  tx_valid_r <= 1'b0;
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
               end
            end
            default: begin
               state_r    <= IDLE;
               tx_valid_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data   = tx_data_r;
   assign tx_valid  = tx_valid_r;
   assign reg_write = reg_write_r;
   assign reg_read  = reg_read_r;
   assign reg_index = reg_index_r;
   assign reg_wdata = reg_wdata_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master: directed frames, frame-level reference model checked every cycle.
module tb_reg_access_master;

   localparam int         T     = 100;
   localparam int         DEPTH = 20;
   localparam logic [7:0] BASE  = 8'h40;
`ifdef REG_ACCESS_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int NLOG = 11 + 2 * CS;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       reg_write;
   logic       reg_read;
   logic [7:0] reg_index;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [7:0] rf [DEPTH];
   logic       rf_load;

   always #5 clk = ~clk;

   reg_access_master #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .reg_write(reg_write), .reg_read(reg_read), .reg_index(reg_index),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
   );

   assign reg_rdata = (reg_index < 8'(DEPTH)) ? rf[reg_index[4:0]] : 8'h00;

   // register file stand-in and cycle counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_load) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= 8'hA0 + 8'(i);
         rf[5] <= 8'h3C;
      end else if (reg_write && reg_index < 8'(DEPTH)) begin
         rf[reg_index[4:0]] <= reg_wdata;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=%02h required=%02h", name, cyc, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic [7:0] q [$];
   logic [7:0] mlog [$];
   logic [7:0] exp_rf [DEPTH];
   logic       m_valid = 1'b0;
   logic       m_resp, m_sw, m_sr, m_txv, m_wr, m_ok, m_in, e_busy;
   logic [7:0] m_idx, m_wd, m_txd, m_rval, m_d;
   int         m_last, m_exec, m_a;

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            e_busy = m_resp || (q.size() > 0 && (cyc - m_last) <= T);
            chk("reg_write", {7'd0, reg_write}, {7'd0, (cyc == m_exec) && m_sw});
            chk("reg_read",  {7'd0, reg_read},  {7'd0, (cyc == m_exec) && m_sr});
            chk("reg_index", reg_index, m_idx);
            chk("reg_wdata", reg_wdata, m_wd);
            chk("tx_valid",  {7'd0, tx_valid},  {7'd0, m_txv});
            chk("busy",      {7'd0, busy},      {7'd0, e_busy});
            if (m_txv) chk("tx_data", tx_data, m_txd);
         end
         if (!rst) begin
            if (!m_valid) begin
               for (int i = 0; i < DEPTH; i++) exp_rf[i] = 8'hA0 + 8'(i);
               exp_rf[5] = 8'h3C;
            end
            m_valid = 1'b1;
            q.delete();
            m_resp = 1'b0; m_txv = 1'b0; m_sw = 1'b0; m_sr = 1'b0;
            m_idx = 8'h00; m_wd = 8'h00; m_txd = 8'h00; m_exec = -10;
         end else if (m_valid) begin
            if (rx_valid && !m_resp) begin
               if (q.size() > 0 && (cyc - m_last) > T) q.delete();
               if (q.size() > 0 || rx_data == 8'h57 || rx_data == 8'h52) begin
                  q.push_back(rx_data);
                  m_last = cyc;
                  if (q.size() == ((q[0] == 8'h57) ? 3 : 2) + CS) begin
                     m_wr = (q[0] == 8'h57);
                     m_a  = int'(q[1]);
                     m_d  = m_wr ? q[2] : 8'h00;
                     m_ok = (CS == 0) || (q[q.size() - 1] == (q[0] ^ q[1] ^ m_d));
                     m_in = (m_a >= int'(BASE)) && (m_a < int'(BASE) + DEPTH);
                     m_exec = cyc + 1;
                     m_resp = 1'b1;
                     m_sw = m_ok && m_in && m_wr;
                     m_sr = m_ok && m_in && !m_wr;
                     if (m_ok && m_in) begin
                        m_idx = 8'(m_a - int'(BASE));
                        if (m_wr) begin
                           m_wd = m_d;
                           exp_rf[m_a - int'(BASE)] = m_d;
                           m_rval = 8'h06;
                        end else begin
                           m_rval = exp_rf[m_a - int'(BASE)];
                        end
                     end else begin
                        m_rval = 8'h15;
                     end
                     q.delete();
                  end
               end
            end
            if (m_txv && tx_ready) begin
               m_txv = 1'b0;
               m_resp = 1'b0;
               mlog.push_back(m_txd);
            end
            if (cyc == m_exec) begin
               m_txv = 1'b1;
               m_txd = m_rval;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] sum_flip);
      send(cmd);
      send(a);
      if (cmd == 8'h57) send(d);
`ifdef REG_ACCESS_CHECKSUM_EN
      send(cmd ^ a ^ ((cmd == 8'h57) ? d : 8'h00) ^ sum_flip);
`endif
   endtask

   logic [7:0] exp_log [13];

   initial begin
      rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; rf_load = 1'b1;
      exp_log[0] = 8'h06; exp_log[1] = 8'h3C; exp_log[2] = 8'h15; exp_log[3]  = 8'h15;
      exp_log[4] = 8'hB3; exp_log[5] = 8'hA1; exp_log[6] = 8'h06; exp_log[7]  = 8'h12;
      exp_log[8] = 8'h3C; exp_log[9] = 8'h06; exp_log[10] = 8'h5A;
      exp_log[11] = 8'h06; exp_log[12] = 8'h15;
      @(posedge clk);
      #1;
      idle(3);
      rst = 1'b1;
      rf_load = 1'b0;
      idle(2);

      send_frame(8'h57, 8'h40, 8'h12, 8'h00);   // write idx0
      idle(4);
      chk("rf0_written", rf[0], 8'h12);
      send_frame(8'h52, 8'h45, 8'h00, 8'h00);   // read preloaded idx5
      idle(4);
      send_frame(8'h57, 8'h54, 8'hAA, 8'h00);   // one past the top
      idle(4);
      send_frame(8'h52, 8'h3F, 8'h00, 8'h00);   // one below the base
      idle(4);
      send_frame(8'h52, 8'h53, 8'h00, 8'h00);   // top entry
      idle(4);
      chk("rf19_kept", rf[19], 8'hB3);

      send(8'h57); send(8'h41);                  // abandoned by timeout
      idle(T);
      send_frame(8'h52, 8'h41, 8'h00, 8'h00);
      idle(4);
      chk("rf1_kept", rf[1], 8'hA1);
      send(8'h57); send(8'h43);                  // longest gap still accepted
      idle(T - 1);
      send(8'h77);
`ifdef REG_ACCESS_CHECKSUM_EN
      send(8'h57 ^ 8'h43 ^ 8'h77);
`endif
      idle(4);
      chk("rf3_written", rf[3], 8'h77);

      send(8'h33);                               // junk discarded in IDLE
      send_frame(8'h52, 8'h40, 8'h00, 8'h00);
      idle(4);

      tx_ready = 1'b0;                           // stalled response, byte injected mid-RESP
      send_frame(8'h52, 8'h45, 8'h00, 8'h00);
      idle(2);
      send(8'h57);
      idle(7);
      tx_ready = 1'b1;
      idle(3);

      send_frame(8'h57, 8'h47, 8'h5A, 8'h00);
      idle(4);
      chk("rf7_written", rf[7], 8'h5A);

      send(8'h57); send(8'h46);                  // reset mid-frame
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      send(8'h99);
      idle(3);
      chk("rf6_kept", rf[6], 8'hA6);

      tx_ready = 1'b0;                           // reset mid-RESP
      send_frame(8'h52, 8'h40, 8'h00, 8'h00);
      idle(3);
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      tx_ready = 1'b1;
      idle(3);

      send_frame(8'h52, 8'h47, 8'h00, 8'h00);
      idle(4);
`ifdef REG_ACCESS_CHECKSUM_EN
      send_frame(8'h57, 8'h42, 8'h05, 8'h00);   // sum 10
      idle(4);
      chk("rf2_written", rf[2], 8'h05);
      send_frame(8'h57, 8'h42, 8'h05, 8'h01);   // sum 11
      idle(4);
`endif

      chk("resp_count", 8'(mlog.size()), 8'(NLOG));
      for (int i = 0; i < NLOG; i++) begin
         if (i < mlog.size()) chk("resp_log", mlog[i], exp_log[i]);
         else chk("resp_log_missing", 8'h00, exp_log[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
